// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, round-robin arbiter in front of a single-port
// synchronous-read memory. One transaction takes four cycles:
//   S_IDLE -> S_ACCESS -> S_WAIT -> S_DONE -> S_IDLE
// The winner's command is presented to memory in S_ACCESS. Read data is
// captured on the S_WAIT -> S_DONE edge. The winner's ready pulses in S_DONE.
//
// Ports
//   clk, reset            sole clock, synchronous active-high reset
//   m0_cmd/addr/wdata     requester 0 (cpu) request, one-hot cmd
//                         (001 none, 010 read, 100 write)
//   m0_rdata/m0_ready     requester 0 registered read data / completion pulse
//   m1_*                  requester 1 (loader/debug), same as m0_*
//   mem_cmd/addr/wdata    memory request
//   mem_rdata             memory read data, valid the cycle after a read
//   grant                 one-hot owner (bit0 = requester 0), 00 when idle
//   err_cmd               sticky illegal-command flag, cleared by reset only
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic [2:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic [2:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          err_cmd
);

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_ptr;     // requester favoured when both request
  logic          r_id;      // latched winner
  logic [2:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_grant;
  logic          r_err;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_m0_ready;
  logic          r_m1_ready;

  logic          w_v0;
  logic          w_v1;
  logic          w_bad0;
  logic          w_bad1;
  logic          w_win;
  logic [2:0]    w_sel_cmd;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Only an exact read or write is a request. Anything outside the three
  // legal one-hot codes is flagged as an error, but it is never granted.
  assign w_v0   = (m0_cmd == MREAD) || (m0_cmd == MWRITE);
  assign w_v1   = (m1_cmd == MREAD) || (m1_cmd == MWRITE);
  assign w_bad0 = !(w_v0 || (m0_cmd == MNONE));
  assign w_bad1 = !(w_v1 || (m1_cmd == MNONE));

  // A lone requester wins. When both request, the priority pointer decides.
  always_comb begin
    w_win = 1'b0;
    if (w_v0 && w_v1) begin
      w_win = r_ptr;
    end else if (w_v1) begin
      w_win = 1'b1;
    end
  end

  assign w_sel_cmd   = w_win ? m1_cmd   : m0_cmd;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_grant    <= '0;
      r_err      <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_bad0 || w_bad1) begin
            r_err <= 1'b1;
          end
          if (w_v0 || w_v1) begin
            r_state <= S_ACCESS;
            r_id    <= w_win;
            r_cmd   <= w_sel_cmd;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_ptr   <= ~w_win;
          end
        end
        S_ACCESS: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Memory read data is valid now, one cycle after the read command.
          r_state <= S_DONE;
          if (r_id) begin
            r_m1_ready <= 1'b1;
            if (r_cmd == MREAD) begin
              r_m1_rdata <= mem_rdata;
            end
          end else begin
            r_m0_ready <= 1'b1;
            if (r_cmd == MREAD) begin
              r_m0_rdata <= mem_rdata;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_grant    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // mem_cmd depends on reset directly. Without that, a reset that lands in
  // S_ACCESS would still commit a write at the reset edge.
  assign mem_cmd   = (reset || (r_state != S_ACCESS)) ? MNONE : r_cmd;
  assign mem_addr  = (r_state == S_IDLE)   ? '0 : r_addr;
  assign mem_wdata = (r_state == S_ACCESS) ? r_wdata : '0;

  assign grant     = r_grant;
  assign err_cmd   = r_err;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_ready  = r_m0_ready;
  assign m1_ready  = r_m1_ready;

endmodule
